// File: rtl/sw_debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sw_debounce_pkg
// Description : Shared definitions for the multi-channel switch conditioner.
//               - per-channel state encoding
//               - raw-polarity normalisation helper
//               - counter-width helper
// Revision    : 1.0  initial release
// ============================================================================
package sw_debounce_pkg;

    // Per-channel conditioner state.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } ch_state_e;

    // Width needed for a counter that must hold 0..limit. A zero limit
    // still gets one bit so the vector stays legal.
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

    // Map a raw switch bit onto pressed = 1.
    function automatic logic norm_pressed(input logic raw, input bit active_low);
        return active_low ? ~raw : raw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sw_debounce_ch.sv
`default_nettype none
// ============================================================================
// Module      : sw_debounce_ch
// Description : One switch channel: counted stability filter on the shared
//               sample tick, IDLE/PRESSED/HELD state machine, and registered
//               single-cycle press/release/long/repeat strobes.
// Ports       : clk, rst_n        clock, async active-low reset
//               i_tick            one-cycle sample strobe from the prescaler
//               i_sample          synchronised switch bit, 1 = pressed
//               o_level           debounced level, 1 = pressed
//               o_press/o_release strobe on debounced press / release
//               o_long            strobe when a press reaches LONG_TICKS
//               o_repeat          strobe with o_long, then every REPEAT_TICKS
// Revision    : 1.0  initial release
// ============================================================================
module sw_debounce_ch
    import sw_debounce_pkg::*;
#(
    parameter int STABLE_TICKS = 3,
    parameter int LONG_TICKS   = 100,
    parameter int REPEAT_TICKS = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_tick,
    input  logic i_sample,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long,
    output logic o_repeat
);

    localparam int c_stab_w = cnt_width(STABLE_TICKS);
    localparam int c_hold_w = cnt_width(LONG_TICKS);
    localparam int c_rep_w  = cnt_width(REPEAT_TICKS);

    // Counters are compared against limit-1 before incrementing, so the
    // terminal event happens on the tick whose incremented value hits limit.
    localparam logic [c_stab_w-1:0] c_stab_last = c_stab_w'(STABLE_TICKS - 1);
    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(LONG_TICKS - 1);
    localparam logic [c_rep_w-1:0]  c_rep_last  =
        c_rep_w'((REPEAT_TICKS > 0) ? REPEAT_TICKS - 1 : 0);
    localparam bit c_rep_en = (REPEAT_TICKS > 0);

    ch_state_e             state_q,   state_d;
    logic                  level_q,   level_d;
    logic                  press_q,   press_d;
    logic                  release_q, release_d;
    logic                  long_q,    long_d;
    logic                  repeat_q,  repeat_d;
    logic [c_stab_w-1:0]   stab_q,    stab_d;
    logic [c_hold_w-1:0]   hold_q,    hold_d;
    logic [c_rep_w-1:0]    rep_q,     rep_d;
    logic                  w_flip;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            stab_q    <= '0;
            hold_q    <= '0;
            rep_q     <= '0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            stab_q    <= stab_d;
            hold_q    <= hold_d;
            rep_q     <= rep_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        stab_d    = stab_q;
        hold_d    = hold_q;
        rep_d     = rep_q;
        w_flip    = 1'b0;

        // Stability filter: any agreeing sample restarts the count.
        if (i_tick) begin
            if (i_sample != level_q) begin
                if (stab_q == c_stab_last) begin
                    w_flip = 1'b1;
                    stab_d = '0;
                end else begin
                    stab_d = stab_q + 1'b1;
                end
            end else begin
                stab_d = '0;
            end
        end

        // The debounced level is 1 exactly when the state is not IDLE, so a
        // flip always means press from IDLE and release otherwise.
        case (state_q)
            ST_IDLE: begin
                hold_d = '0;
                rep_d  = '0;
                if (w_flip) begin
                    state_d = ST_PRESSED;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end
            end
            ST_PRESSED: begin
                if (w_flip) begin
                    state_d   = ST_IDLE;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                    hold_d    = '0;
                end else if (i_tick) begin
                    if (hold_q == c_hold_last) begin
                        state_d  = ST_HELD;
                        long_d   = 1'b1;
                        repeat_d = c_rep_en;
                        rep_d    = '0;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
            ST_HELD: begin
                // A release on this tick wins over any repeat due now.
                if (w_flip) begin
                    state_d   = ST_IDLE;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                    hold_d    = '0;
                    rep_d     = '0;
                end else if (i_tick && c_rep_en) begin
                    if (rep_q == c_rep_last) begin
                        repeat_d = 1'b1;
                        rep_d    = '0;
                    end else begin
                        rep_d = rep_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                level_d = 1'b0;
                hold_d  = '0;
                rep_d   = '0;
            end
        endcase
    end

    assign o_level   = level_q;
    assign o_press   = press_q;
    assign o_release = release_q;
    assign o_long    = long_q;
    assign o_repeat  = repeat_q;

endmodule
`default_nettype wire

// File: rtl/sw_debounce_multi.sv
`default_nettype none
// ============================================================================
// Module      : sw_debounce_multi
// Description : Multi-channel push-button conditioner. Two-flop synchroniser
//               per switch, one shared sample-tick prescaler, and NUM_CH
//               independent sw_debounce_ch channels.
// Ports       : clk, rst_n  clock, async active-low reset
//               i_sw        raw switch inputs (asynchronous)
//               o_level     debounced levels, 1 = pressed
//               o_press     press strobes      o_release  release strobes
//               o_long      long-press strobes o_repeat   auto-repeat strobes
// Revision    : 1.0  initial release
// ============================================================================
module sw_debounce_multi
    import sw_debounce_pkg::*;
#(
    parameter int NUM_CH       = 3,
    parameter bit ACTIVE_LOW   = 1'b1,
    parameter int TICK_DIV     = 500000,
    parameter int STABLE_TICKS = 3,
    parameter int LONG_TICKS   = 100,
    parameter int REPEAT_TICKS = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] i_sw,
    output logic [NUM_CH-1:0] o_level,
    output logic [NUM_CH-1:0] o_press,
    output logic [NUM_CH-1:0] o_release,
    output logic [NUM_CH-1:0] o_long,
    output logic [NUM_CH-1:0] o_repeat
);

    localparam int                  c_div_w    = cnt_width(TICK_DIV - 1);
    localparam logic [c_div_w-1:0]  c_div_last = c_div_w'(TICK_DIV - 1);
    // Synchronisers reset to the released raw level so no phantom press
    // appears when reset is removed with all switches open.
    localparam logic [NUM_CH-1:0]   c_sync_rst = {NUM_CH{ACTIVE_LOW}};

    logic [NUM_CH-1:0]  sync1_q;
    logic [NUM_CH-1:0]  sync2_q;
    logic [c_div_w-1:0] div_q, div_d;
    logic               w_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= c_sync_rst;
            sync2_q <= c_sync_rst;
        end else begin
            sync1_q <= i_sw;
            sync2_q <= sync1_q;
        end
    end

    assign w_tick = (div_q == c_div_last);
    assign div_d  = w_tick ? '0 : div_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic w_sample;

        assign w_sample = norm_pressed(sync2_q[gi], ACTIVE_LOW);

        sw_debounce_ch #(
            .STABLE_TICKS (STABLE_TICKS),
            .LONG_TICKS   (LONG_TICKS),
            .REPEAT_TICKS (REPEAT_TICKS)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_tick    (w_tick),
            .i_sample  (w_sample),
            .o_level   (o_level[gi]),
            .o_press   (o_press[gi]),
            .o_release (o_release[gi]),
            .o_long    (o_long[gi]),
            .o_repeat  (o_repeat[gi])
        );
    end

endmodule
`default_nettype wire
